// File: rtl/sl3_sync_lock_if.sv
`default_nettype none
// ============================================================================
// Module   : sl3_sync_lock_if
// Purpose  : Word-qualifier inputs and lock-status outputs of the metaframe
//            sync-lock block, bundled for connection between the upstream
//            datapath (master) and the lock block (slave).
// Revision : 1.0  initial release
// ============================================================================
interface sl3_sync_lock_if;
    logic        din_valid;
    logic        match;
    logic        locked;
    logic        frame_start;
    logic        sync_err;
    logic        lock_lost;
    logic [15:0] word_pos;
    logic [15:0] err_count;

    modport master (
        output din_valid, match,
        input  locked, frame_start, sync_err, lock_lost, word_pos, err_count
    );

    modport slave (
        input  din_valid, match,
        output locked, frame_start, sync_err, lock_lost, word_pos, err_count
    );
endinterface
`default_nettype wire

// File: rtl/sl3_sync_lock.sv
`default_nettype none
// ============================================================================
// Module   : sl3_sync_lock
// Purpose  : Metaframe sync-word lock FSM (HUNT / VERIFY / LOCKED) with
//            position tracking, sync-error pulses and a saturating error count.
// Revision : 1.0  initial release
// ============================================================================
module sl3_sync_lock #(
    parameter int META_LEN = 2048,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  wire logic       clk,
    input  wire logic       sclr,
    sl3_sync_lock_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [15:0] c_LAST_POS = 16'(META_LEN - 1);
    localparam logic [3:0]  c_LOCK     = 4'(LOCK_CNT);
    localparam logic [3:0]  c_LOSS     = 4'(LOSS_CNT);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_good, w_good_nxt;
    logic [3:0]  r_bad, w_bad_nxt;
    logic [15:0] r_pos, w_pos_nxt;
    logic [15:0] r_err_count, w_err_nxt;
    logic        r_locked, r_frame_start, r_sync_err, r_lock_lost;
    logic        w_fs, w_se, w_ll;
    logic [15:0] w_cur_pos;
    logic [3:0]  w_good_inc, w_bad_inc;

    // Position the current word would occupy if we are tracking a metaframe.
    assign w_cur_pos  = (r_pos == c_LAST_POS) ? 16'd0 : r_pos + 16'd1;
    assign w_good_inc = r_good + 4'd1;
    assign w_bad_inc  = r_bad + 4'd1;

    // Next-state, counter and pulse decode; invalid cycles hold everything.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_pos_nxt   = r_pos;
        w_err_nxt   = r_err_count;
        w_fs        = 1'b0;
        w_se        = 1'b0;
        w_ll        = 1'b0;
        if (bus.din_valid) begin
            case (r_state)
                ST_HUNT: begin
                    // The hunted word becomes slot 0 of a candidate metaframe.
                    w_pos_nxt = 16'd0;
                    if (bus.match) begin
                        w_good_nxt = 4'd1;
                        w_bad_nxt  = 4'd0;
                        if (c_LOCK == 4'd1) begin
                            w_state_nxt = ST_LOCKED;
                            w_fs        = 1'b1;
                        end else begin
                            w_state_nxt = ST_VERIFY;
                        end
                    end else begin
                        w_good_nxt = 4'd0;
                    end
                end
                ST_VERIFY: begin
                    w_pos_nxt = w_cur_pos;
                    if (w_cur_pos == 16'd0) begin
                        if (bus.match) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == c_LOCK) begin
                                w_state_nxt = ST_LOCKED;
                                w_bad_nxt   = 4'd0;
                                w_fs        = 1'b1;
                            end
                        end else begin
                            // Candidate rejected silently; not yet locked.
                            w_state_nxt = ST_HUNT;
                            w_good_nxt  = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    w_pos_nxt = w_cur_pos;
                    if (w_cur_pos == 16'd0) begin
                        if (bus.match) begin
                            w_bad_nxt = 4'd0;
                            w_fs      = 1'b1;
                        end else begin
                            w_se      = 1'b1;
                            w_bad_nxt = w_bad_inc;
                            if (w_bad_inc == c_LOSS) begin
                                w_state_nxt = ST_HUNT;
                                w_ll        = 1'b1;
                                w_good_nxt  = 4'd0;
                                w_bad_nxt   = 4'd0;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_good_nxt  = 4'd0;
                    w_bad_nxt   = 4'd0;
                    w_pos_nxt   = 16'd0;
                end
            endcase
            if (w_se && (r_err_count != 16'hFFFF)) begin
                w_err_nxt = r_err_count + 16'd1;
            end
        end
    end

    // State, counters and registered outputs; sclr overrides every input.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state       <= ST_HUNT;
            r_good        <= 4'd0;
            r_bad         <= 4'd0;
            r_pos         <= 16'd0;
            r_err_count   <= 16'd0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
            r_lock_lost   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_good        <= w_good_nxt;
            r_bad         <= w_bad_nxt;
            r_pos         <= w_pos_nxt;
            r_err_count   <= w_err_nxt;
            r_locked      <= (w_state_nxt == ST_LOCKED);
            r_frame_start <= w_fs;
            r_sync_err    <= w_se;
            r_lock_lost   <= w_ll;
        end
    end

    assign bus.locked      = r_locked;
    assign bus.frame_start = r_frame_start;
    assign bus.sync_err    = r_sync_err;
    assign bus.lock_lost   = r_lock_lost;
    assign bus.word_pos    = r_pos;
    assign bus.err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_sl3_sync_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_sl3_sync_lock
// Purpose  : Directed self-checking bench for sl3_sync_lock with
//            META_LEN=8, LOCK_CNT=3, LOSS_CNT=2.
// Revision : 1.0  initial release
// ============================================================================
module tb_sl3_sync_lock;

    logic clk;
    logic sclr;
    int   checks;
    int   errors;

    sl3_sync_lock_if bus ();

    sl3_sync_lock #(
        .META_LEN (8),
        .LOCK_CNT (3),
        .LOSS_CNT (2)
    ) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare every output against hand-derived values for one step.
    task automatic chk_all(input string sc, input int i, input logic fs, input logic se,
                           input logic ll, input logic lk, input int wp, input int ec);
        chk($sformatf("%s[%0d].frame_start", sc, i), 32'(bus.frame_start), 32'(fs));
        chk($sformatf("%s[%0d].sync_err", sc, i),    32'(bus.sync_err),    32'(se));
        chk($sformatf("%s[%0d].lock_lost", sc, i),   32'(bus.lock_lost),   32'(ll));
        chk($sformatf("%s[%0d].locked", sc, i),      32'(bus.locked),      32'(lk));
        chk($sformatf("%s[%0d].word_pos", sc, i),    32'(bus.word_pos),    32'(wp));
        chk($sformatf("%s[%0d].err_count", sc, i),   32'(bus.err_count),   32'(ec));
    endtask

    // One clock with the given inputs; returns 1 ns after the edge.
    task automatic step(input logic v, input logic m);
        bus.din_valid = v;
        bus.match     = m;
        @(posedge clk);
        #1;
    endtask

    // One-cycle sclr with inputs deliberately active to prove priority.
    task automatic do_reset();
        sclr = 1'b1;
        step(1'b1, 1'b1);
        sclr = 1'b0;
        bus.din_valid = 1'b0;
        bus.match     = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sclr   = 1'b0;
        bus.din_valid = 1'b0;
        bus.match     = 1'b0;
        @(posedge clk);
        #1;

        // Reset state.
        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

        // Acquire on 0/8/16, then miss 24 and 32 -> loss of lock.
        for (int i = 0; i <= 39; i++) begin
            step(1'b1, (i % 8 == 0) && (i != 24) && (i != 32));
            chk_all("loss", i, i == 16, (i == 24) || (i == 32), i == 32,
                    (i >= 16) && (i < 32), (i <= 32) ? i % 8 : 0,
                    (i < 24) ? 0 : (i < 32) ? 1 : 2);
        end

        // Single miss at 24 recovered at 32; bad cleared so miss at 48 keeps lock.
        do_reset();
        for (int i = 0; i <= 48; i++) begin
            step(1'b1, (i % 8 == 0) && (i != 24) && (i != 48));
            chk_all("recover", i, (i == 16) || (i == 32) || (i == 40),
                    (i == 24) || (i == 48), 0, i >= 16, i % 8,
                    (i < 24) ? 0 : (i < 48) ? 1 : 2);
        end

        // VERIFY broken at 8, re-acquire from 11, lock after word 27.
        do_reset();
        for (int i = 0; i <= 27; i++) begin
            step(1'b1, (i == 0) || (i == 11) || (i == 19) || (i == 27));
            chk_all("reacq", i, i == 27, 0, 0, i == 27,
                    (i < 8) ? i : (i < 11) ? 0 : (i - 11) % 8, 0);
        end

        // Valid toggling; match held high on idle cycles must be ignored.
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            step(1'b1, k % 8 == 0);
            chk_all("toggle_v", k, k == 16, 0, 0, k >= 16, k % 8, 0);
            step(1'b0, 1'b1);
            chk_all("toggle_i", k, 0, 0, 0, k >= 16, k % 8, 0);
        end

        // Lock, take one error, advance to position 5, then sclr.
        do_reset();
        for (int i = 0; i <= 29; i++) begin
            step(1'b1, (i % 8 == 0) && (i != 24));
        end
        chk_all("pre_clr", 29, 0, 0, 0, 1, 5, 1);
        do_reset();
        chk_all("sclr", 0, 0, 0, 0, 0, 0, 0);

        // No residual good count: two syncs must not lock, the third does.
        for (int i = 0; i <= 16; i++) begin
            step(1'b1, i % 8 == 0);
            if (i == 8 || i == 16) begin
                chk_all("restart", i, i == 16, 0, 0, i == 16, 0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
